store_trace_buf: RTL and testbench

STORE_TRACE_BUF -- requirements
Module: store_trace_buf

---
 rtl/trace_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/store_trace_buf.sv | 105 ++++++++++
 tb/tb_store_trace_buf.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the store trace buffer: display FSM states and the
// captured store entry (address + data).
package trace_pkg;

    localparam int ENTRY_MAX_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } trace_state_e;

    // Fields are sized for the widest supported bus; narrower instances zero-extend.
    typedef struct packed {
        logic [ENTRY_MAX_W-1:0] addr;
        logic [ENTRY_MAX_W-1:0] data;
    } trace_entry_t;

    function automatic logic [9:0] low10(input logic [ENTRY_MAX_W-1:0] word);
        return word[9:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/store_trace_buf.sv
// Captures CPU stores that fall in an address window and shows them one at a
// time on a slow display, each held for HOLD_CYCLES clocks.
module store_trace_buf
    import trace_pkg::*;
#(
    parameter int              DATA_WIDTH  = 32,
    parameter int              DEPTH       = 8,
    parameter int              HOLD_CYCLES = 50_000_000,
    parameter longint unsigned CAP_BASE    = 0,
    parameter longint unsigned CAP_SPAN    = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_write,
    input  logic [DATA_WIDTH-1:0]       data_addr,
    input  logic [DATA_WIDTH-1:0]       write_data,
    output logic [9:0]                  disp_addr,
    output logic [9:0]                  disp_data,
    output logic                        disp_valid,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
    output logic                        overflow,
    output trace_state_e                state_dbg
);

    localparam int AW = DATA_WIDTH + 1;
    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [AW-1:0] CAP_LO = AW'(CAP_BASE);
    localparam logic [AW-1:0] CAP_HI = AW'(CAP_BASE + CAP_SPAN);

    trace_state_e              state;
    logic [TW-1:0]             timer;
    logic                      qualify;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [2*DATA_WIDTH-1:0]   fifo_rdata;
    trace_entry_t              head;

    // mem_write is a one-cycle strobe with no ready back-pressure: every
    // qualifying store is either pushed or counted as a drop on that edge.
    assign qualify = mem_write
                  && ({1'b0, data_addr} >= CAP_LO)
                  && ({1'b0, data_addr} <  CAP_HI);

    assign pop = !fifo_empty && ((state == IDLE) || (timer == '0));

    assign head.addr = ENTRY_MAX_W'(fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign head.data = ENTRY_MAX_W'(fifo_rdata[DATA_WIDTH-1:0]);
    assign state_dbg = state;

    sync_fifo #(
        .DATA_WIDTH (2*DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (qualify),
        .wdata ({data_addr, write_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            // A full FIFO still takes the store when the display pops on this edge.
            if (qualify && fifo_full && !pop) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        disp_addr  <= low10(head.addr);
                        disp_data  <= low10(head.data);
                        disp_valid <= 1'b1;
                        timer      <= TW'(HOLD_CYCLES - 1);
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (!fifo_empty) begin
                        disp_addr  <= low10(head.addr);
                        disp_data  <= low10(head.data);
                        disp_valid <= 1'b1;
                        timer      <= TW'(HOLD_CYCLES - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_trace_buf.sv
// Directed bench for store_trace_buf with DEPTH=4, HOLD_CYCLES=4, window [0,1024).
module tb_store_trace_buf;
    import trace_pkg::*;

    logic         clk;
    logic         reset;
    logic         mem_write;
    logic [31:0]  data_addr;
    logic [31:0]  write_data;
    logic [9:0]   disp_addr;
    logic [9:0]   disp_data;
    logic         disp_valid;
    logic [2:0]   fifo_count;
    logic         overflow;
    trace_state_e state_dbg;

    int n_cmp;
    int n_bad;

    store_trace_buf #(
        .DATA_WIDTH  (32),
        .DEPTH       (4),
        .HOLD_CYCLES (4),
        .CAP_BASE    (0),
        .CAP_SPAN    (1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_addr  (data_addr),
        .write_data (write_data),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks: inputs change on the falling edge, outputs sampled there too
    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_write = 1'b0;
        wait_neg(2);
        reset = 1'b0;
    endtask

    task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d);
        mem_write  = mw;
        data_addr  = a;
        write_data = d;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++; if (disp_addr !== 10'd0) begin n_bad++; $display("FAIL reset_disp_addr: got %0d want 0", disp_addr); end
        n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_disp_valid: got %0b want 0", disp_valid); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        n_cmp++; if (state_dbg !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_single();
        apply_reset();
        drive(1'b1, 32'h10, 32'd7);
        wait_neg(1);                      // after edge N
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count_n: got %0d want 1", fifo_count); end
        n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass: got %0b want 0", disp_valid); end
        wait_neg(1);                      // after edge N+1
        n_cmp++; if (disp_addr !== 10'd16) begin n_bad++; $display("FAIL single_addr: got %0d want 16", disp_addr); end
        n_cmp++; if (disp_data !== 10'd7) begin n_bad++; $display("FAIL single_data: got %0d want 7", disp_data); end
        n_cmp++; if (disp_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0b want 1", disp_valid); end
        n_cmp++; if (state_dbg !== HOLD) begin n_bad++; $display("FAIL single_hold: got %0d want HOLD", state_dbg); end
        wait_neg(3);                      // after edge N+4
        n_cmp++; if (state_dbg !== HOLD) begin n_bad++; $display("FAIL single_still_hold: got %0d want HOLD", state_dbg); end
        wait_neg(1);                      // after edge N+5
        n_cmp++; if (state_dbg !== IDLE) begin n_bad++; $display("FAIL single_idle: got %0d want IDLE", state_dbg); end
        n_cmp++; if (disp_addr !== 10'd16) begin n_bad++; $display("FAIL single_held_addr: got %0d want 16", disp_addr); end
    endtask

    task automatic test_burst();
        apply_reset();
        drive(1'b1, 32'd0, 32'd1);
        wait_neg(1);                      // N
        drive(1'b1, 32'd4, 32'd2);
        wait_neg(1);                      // N+1
        drive(1'b1, 32'd8, 32'd3);
        n_cmp++; if (disp_data !== 10'd1) begin n_bad++; $display("FAIL burst_first: got %0d want 1", disp_data); end
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL burst_count_n1: got %0d want 1", fifo_count); end
        wait_neg(1);                      // N+2
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL burst_peak: got %0d want 2", fifo_count); end
        wait_neg(2);                      // N+4
        n_cmp++; if (disp_data !== 10'd1) begin n_bad++; $display("FAIL burst_hold_first: got %0d want 1", disp_data); end
        wait_neg(1);                      // N+5
        n_cmp++; if (disp_data !== 10'd2 || disp_addr !== 10'd4) begin n_bad++; $display("FAIL burst_second: got %0d/%0d want 4/2", disp_addr, disp_data); end
        wait_neg(3);                      // N+8
        n_cmp++; if (disp_data !== 10'd2) begin n_bad++; $display("FAIL burst_hold_second: got %0d want 2", disp_data); end
        wait_neg(1);                      // N+9
        n_cmp++; if (disp_data !== 10'd3 || disp_addr !== 10'd8) begin n_bad++; $display("FAIL burst_third: got %0d/%0d want 8/3", disp_addr, disp_data); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL burst_drained: got %0d want 0", fifo_count); end
    endtask

    // The 6th store lands on the edge where the first held entry expires, so
    // the pop frees a slot; the 7th store meets a full FIFO and is dropped.
    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'(i * 4), 32'(i + 1));
            wait_neg(1);                  // after edge N+i
            if (i == 5) begin
                n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_pop_count: got %0d want 4", fifo_count); end
                n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_pop_overflow: got %0b want 0", overflow); end
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL drop_count: got %0d want 4", fifo_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL drop_overflow: got %0b want 1", overflow); end
        wait_neg(15);                     // N+21: last accepted entry shown
        n_cmp++; if (disp_data !== 10'd6 || disp_addr !== 10'd20) begin n_bad++; $display("FAIL b2b_last: got %0d/%0d want 20/6", disp_addr, disp_data); end
        wait_neg(4);                      // N+25
        n_cmp++; if (state_dbg !== IDLE || disp_data !== 10'd6) begin n_bad++; $display("FAIL b2b_end: got state %0d data %0d want IDLE/6", state_dbg, disp_data); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_window();
        apply_reset();
        drive(1'b1, 32'h400, 32'd5);
        wait_neg(1);                      // N
        drive(1'b1, 32'h3FF, 32'd9);
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL window_reject: got %0d want 0", fifo_count); end
        wait_neg(1);                      // N+1
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL window_accept: got %0d want 1", fifo_count); end
        wait_neg(1);                      // N+2
        n_cmp++; if (disp_addr !== 10'd1023 || disp_data !== 10'd9) begin n_bad++; $display("FAIL window_disp: got %0d/%0d want 1023/9", disp_addr, disp_data); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 32'(i + 1));
            wait_neg(1);
        end
        n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL mid_queued: got %0d want 3", fifo_count); end
        reset = 1'b1;                     // strobe still high while in reset
        #1;
        n_cmp++; if (disp_addr !== 10'd0 || disp_data !== 10'd0 || disp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_disp_clear: got %0d/%0d/%0b want 0/0/0", disp_addr, disp_data, disp_valid); end
        n_cmp++; if (fifo_count !== 3'd0 || overflow !== 1'b0 || state_dbg !== IDLE) begin n_bad++; $display("FAIL mid_state_clear: got cnt %0d ovf %0b st %0d want 0/0/IDLE", fifo_count, overflow, state_dbg); end
        wait_neg(1);
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_store_ignored: got %0d want 0", fifo_count); end
        reset = 1'b0;
        drive(1'b1, 32'd8, 32'd1);
        wait_neg(1);                      // N
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if (fifo_count !== 3'd1 || disp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_after_n: got cnt %0d valid %0b want 1/0", fifo_count, disp_valid); end
        wait_neg(1);                      // N+1
        n_cmp++; if (disp_addr !== 10'd8 || disp_data !== 10'd1 || disp_valid !== 1'b1) begin n_bad++; $display("FAIL mid_after_n1: got %0d/%0d/%0b want 8/1/1", disp_addr, disp_data, disp_valid); end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        mem_write  = 1'b0;
        data_addr  = '0;
        write_data = '0;
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_window();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
